// File: rtl/alu_codes_pkg.sv
// Operation encoding for the pico-MIPS ALU, shared with the decoder/control unit.
// Also holds small helpers used by the ALU datapath.
package alu_codes_pkg;

    typedef enum logic [2:0] {
        RA   = 3'd0,
        RB   = 3'd1,
        RADD = 3'd2,
        RSUB = 3'd3,
        RAND = 3'd4,
        ROR  = 3'd5,
        RXOR = 3'd6,
        RNOR = 3'd7
    } alu_func_t;

    // Only the adder ops produce meaningful carry/overflow flags.
    function automatic logic is_arith(input alu_func_t f);
        return (f == RADD) || (f == RSUB);
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for RADD/RSUB: subtraction is a + ~b + 1 through the same carry chain.
// cout is the raw carry-out; for subtraction it is the inverse of borrow.
module alu_addsub #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    // Signed overflow: both adder inputs share a sign that the sum does not.
    assign ovf = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/alu.sv
// N-bit registered ALU for the pico-MIPS datapath; one-cycle latency, new op every cycle.
// Define ALU_FLAGS_EN to add registered carry/borrow (CF) and signed-overflow (VF) outputs.
module alu
    import alu_codes_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   func,
    output logic [N-1:0] result,
    output logic         ZF
`ifdef ALU_FLAGS_EN
    ,
    output logic         CF,
    output logic         VF
`endif
);

    alu_func_t    op;
    logic         sub;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [N-1:0] result_nxt;

    assign op  = alu_func_t'(func);
    assign sub = (op == RSUB);

    alu_addsub #(.N(N)) u_addsub (
        .a    (a),
        .b    (b),
        .sub  (sub),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always_comb begin
        result_nxt = '0;
        case (op)
            RA:   result_nxt = a;
            RB:   result_nxt = b;
            RADD: result_nxt = sum;
            RSUB: result_nxt = sum;
            RAND: result_nxt = a & b;
            ROR:  result_nxt = a | b;
            RXOR: result_nxt = a ^ b;
            RNOR: result_nxt = ~(a | b);
        endcase
    end

    // ZF comes from the same next-state value so it can never disagree with result.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            ZF     <= 1'b1;
        end else begin
            result <= result_nxt;
            ZF     <= (result_nxt == '0);
        end
    end

`ifdef ALU_FLAGS_EN
    logic cf_nxt;
    logic vf_nxt;

    always_comb begin
        cf_nxt = 1'b0;
        vf_nxt = 1'b0;
        if (is_arith(op)) begin
            // For subtraction the adder's carry-out means "no borrow".
            cf_nxt = sub ? ~cout : cout;
            vf_nxt = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CF <= 1'b0;
            VF <= 1'b0;
        end else begin
            CF <= cf_nxt;
            VF <= vf_nxt;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = cout ^ ovf;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the pico-MIPS ALU (N=8), hand-computed expectations.
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_alu;
    import alu_codes_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   func;
    logic [N-1:0] result;
    logic         ZF;
`ifdef ALU_FLAGS_EN
    logic         CF;
    logic         VF;
`endif

    int total = 0;
    int bad   = 0;

    alu #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .a      (a),
        .b      (b),
        .func   (func),
        .result (result),
        .ZF     (ZF)
`ifdef ALU_FLAGS_EN
        ,
        .CF     (CF),
        .VF     (VF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation, let it be captured, then sample 1 time unit after the edge.
    task automatic apply(input logic [N-1:0] av, input logic [N-1:0] bv, input alu_func_t f,
                         input logic rst);
        a     = av;
        b     = bv;
        func  = f;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(8'd200, 8'd100, RADD, 1'b0);
        apply(8'd5, 8'd17, RADD, 1'b1);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL reset: result=%0d ZF=%0b, expected result=0 ZF=1", result, ZF);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b0 || VF !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: CF=%0b VF=%0b, expected 0 0", CF, VF);
        end
`endif
        apply(8'd5, 8'd17, RADD, 1'b0);
        total++;
        if (result !== 8'd22 || ZF !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: result=%0d ZF=%0b, expected 22 0", result, ZF);
        end
    endtask

    task automatic test_ops();
        logic [N-1:0] exp_r [8];
        logic         exp_cf [8];
        exp_r  = '{8'd5, 8'd17, 8'd22, 8'd244, 8'd1, 8'd21, 8'd20, 8'd234};
        exp_cf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            apply(8'd5, 8'd17, alu_func_t'(i[2:0]), 1'b0);
            total++;
            if (result !== exp_r[i] || ZF !== 1'b0) begin
                bad++;
                $display("FAIL op_%0d: result=%0d ZF=%0b, expected %0d 0", i, result, ZF, exp_r[i]);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if (CF !== exp_cf[i] || VF !== 1'b0) begin
                bad++;
                $display("FAIL op_%0d_flags: CF=%0b VF=%0b, expected %0b 0", i, CF, VF, exp_cf[i]);
            end
`else
            if (exp_cf[i] === 1'bx) $display("unreachable");
`endif
        end
    endtask

    task automatic test_zero();
        apply(8'd17, 8'd17, RSUB, 1'b0);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL zero_sub: result=%0d ZF=%0b, expected 0 1", result, ZF);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b0 || VF !== 1'b0) begin
            bad++;
            $display("FAIL zero_sub_flags: CF=%0b VF=%0b, expected 0 0", CF, VF);
        end
`endif
        apply(8'd17, 8'd17, RXOR, 1'b0);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL zero_xor: result=%0d ZF=%0b, expected 0 1", result, ZF);
        end
        apply(8'd255, 8'd0, RNOR, 1'b0);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL zero_nor: result=%0d ZF=%0b, expected 0 1", result, ZF);
        end
        apply(8'd0, 8'd9, RA, 1'b0);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL zero_pass_a: result=%0d ZF=%0b, expected 0 1", result, ZF);
        end
    endtask

    task automatic test_carry();
        apply(8'd200, 8'd100, RADD, 1'b0);
        total++;
        if (result !== 8'd44 || ZF !== 1'b0) begin
            bad++;
            $display("FAIL wrap_add: result=%0d ZF=%0b, expected 44 0", result, ZF);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b1 || VF !== 1'b0) begin
            bad++;
            $display("FAIL wrap_add_flags: CF=%0b VF=%0b, expected 1 0", CF, VF);
        end
`endif
        apply(8'd100, 8'd100, RADD, 1'b0);
        total++;
        if (result !== 8'd200) begin
            bad++;
            $display("FAIL ovf_add: result=%0d, expected 200", result);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b0 || VF !== 1'b1) begin
            bad++;
            $display("FAIL ovf_add_flags: CF=%0b VF=%0b, expected 0 1", CF, VF);
        end
`endif
        apply(8'd255, 8'd1, RADD, 1'b0);
        total++;
        if (result !== 8'd0 || ZF !== 1'b1) begin
            bad++;
            $display("FAIL wrap_255_1: result=%0d ZF=%0b, expected 0 1", result, ZF);
        end
    endtask

    task automatic test_borrow();
        apply(8'd5, 8'd17, RSUB, 1'b0);
        total++;
        if (result !== 8'd244) begin
            bad++;
            $display("FAIL borrow_sub: result=%0d, expected 244", result);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b1 || VF !== 1'b0) begin
            bad++;
            $display("FAIL borrow_sub_flags: CF=%0b VF=%0b, expected 1 0", CF, VF);
        end
`endif
        apply(8'd128, 8'd1, RSUB, 1'b0);
        total++;
        if (result !== 8'd127) begin
            bad++;
            $display("FAIL ovf_sub: result=%0d, expected 127", result);
        end
`ifdef ALU_FLAGS_EN
        total++;
        if (CF !== 1'b0 || VF !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sub_flags: CF=%0b VF=%0b, expected 0 1", CF, VF);
        end
`endif
    endtask

    // Inputs change right after each edge, before sampling, so any output that is not
    // registered (or uses the wrong cycle's inputs) shows up as a mismatch.
    task automatic test_back_to_back();
        logic [N-1:0] va [7];
        logic [N-1:0] vb [7];
        alu_func_t    vf [7];
        logic         vr [7];
        logic [N-1:0] er [7];
        logic         ez [7];
        va = '{8'd10, 8'd10, 8'd255, 8'd12, 8'd12, 8'd0,  8'd3};
        vb = '{8'd3,  8'd3,  8'd1,   8'd10, 8'd10, 8'd0,  8'd250};
        vf = '{RSUB,  RAND,  RADD,   ROR,   RB,    RA,    RNOR};
        vr = '{1'b0,  1'b0,  1'b1,   1'b0,  1'b0,  1'b0,  1'b0};
        er = '{8'd7,  8'd2,  8'd0,   8'd14, 8'd10, 8'd0,  8'd4};
        ez = '{1'b0,  1'b0,  1'b1,   1'b0,  1'b0,  1'b1,  1'b0};
        a = va[0]; b = vb[0]; func = vf[0]; reset = vr[0];
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            if (i < 6) begin
                a = va[i+1]; b = vb[i+1]; func = vf[i+1]; reset = vr[i+1];
            end else begin
                a = 8'd0; b = 8'd0; func = RADD; reset = 1'b0;
            end
            #1;
            total++;
            if (result !== er[i] || ZF !== ez[i]) begin
                bad++;
                $display("FAIL b2b_%0d: result=%0d ZF=%0b, expected %0d %0b", i, result, ZF,
                         er[i], ez[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        func  = RA;
        test_reset();
        test_ops();
        test_zero();
        test_carry();
        test_borrow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
